// File: rtl/ble_cmd_host.sv
// ble_cmd_host: host-side UART command issuer for the robot link.
// Sends a 16-bit command as two 8N1 frames and tracks response bytes.
module ble_cmd_host #(
  parameter int unsigned BAUD_DIV     = 5208,
  parameter logic [31:0] RESP_TIMEOUT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        busy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        cmd_done,
  output logic        timeout
);

  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] TMO_LAST  = RESP_TIMEOUT - 32'd1;

  typedef enum logic [1:0] {
    S_IDLE, S_TX_HI, S_TX_LO, S_WAIT
  } state_e;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
  } rx_state_e;

  state_e      state_q, state_d;
  logic [15:0] cmd_q;
  logic [9:0]  tx_sh_q;
  logic [15:0] baud_q;
  logic [3:0]  bit_q;
  logic [31:0] tmo_q;

  rx_state_e   rx_state_q, rx_state_d;
  logic        rx_s1_q, rx_s2_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;
  logic [7:0]  resp_q;
  logic        rdy_q, done_q, tmo_p_q;

  logic accept, in_tx, in_wait;
  logic baud_end, frame_end;
  logic rx_half, rx_full, rx_ok;
  logic done_hit, tmo_hit;

  assign baud_end = baud_q == BIT_LAST;
  assign rx_half  = rx_cnt_q == HALF_LAST;
  assign rx_full  = rx_cnt_q == BIT_LAST;
  assign rx_ok    = rx_state_q == R_STOP && rx_full && rx_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (send_cmd)            state_d = S_TX_HI;
      S_TX_HI: if (frame_end)           state_d = S_TX_LO;
      S_TX_LO: if (frame_end)           state_d = S_WAIT;
      S_WAIT:  if (done_q || tmo_hit)   state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // done_q holds WAIT one extra cycle so busy drops after cmd_done
  always_comb begin
    accept  = 1'b0;
    in_tx   = 1'b0;
    in_wait = 1'b0;
    unique case (state_q)
      S_IDLE:          accept  = send_cmd;
      S_TX_HI, S_TX_LO: in_tx  = 1'b1;
      S_WAIT:          in_wait = 1'b1;
      default: ;
    endcase
    busy      = state_q != S_IDLE;
    frame_end = in_tx && baud_end && bit_q == 4'd9;
    done_hit  = in_wait && !done_q && rx_ok
                && rx_sh_q == 8'hA5;
    tmo_hit   = in_wait && !done_q && !rx_ok
                && tmo_q == TMO_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      tx_sh_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else if (accept) begin
      cmd_q   <= cmd;
      tx_sh_q <= {1'b1, cmd[15:8], 1'b0};
      baud_q  <= '0;
      bit_q   <= '0;
    end else if (in_tx) begin
      if (!baud_end) begin
        baud_q <= baud_q + 16'd1;
      end else begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          bit_q <= '0;
          if (state_q == S_TX_HI)
            tx_sh_q <= {1'b1, cmd_q[7:0], 1'b0};
          else
            tx_sh_q <= '1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_sh_q <= {1'b1, tx_sh_q[9:1]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_q <= '0;
    else if (!in_wait || rx_ok) tmo_q <= '0;
    else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + 32'd1;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      R_IDLE:  if (!rx_s2_q) rx_state_d = R_START;
      R_START: if (rx_half)
                 rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
      R_DATA:  if (rx_full && rx_bit_q == 3'd7)
                 rx_state_d = R_STOP;
      R_STOP:  if (rx_full)
                 rx_state_d = rx_s2_q ? R_IDLE : R_BREAK;
      R_BREAK: if (rx_s2_q) rx_state_d = R_IDLE;
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_state_q <= rx_state_d;
      if (rx_state_d != rx_state_q || rx_full)
        rx_cnt_q <= '0;
      else if (rx_state_q inside {R_START, R_DATA, R_STOP})
        rx_cnt_q <= rx_cnt_q + 16'd1;
      if (rx_state_q == R_START) begin
        rx_bit_q <= '0;
      end else if (rx_state_q == R_DATA && rx_full) begin
        rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
        if (rx_bit_q != 3'd7) rx_bit_q <= rx_bit_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_p_q <= 1'b0;
    end else begin
      if (rx_ok) resp_q <= rx_sh_q;
      rdy_q   <= rx_ok;
      done_q  <= done_hit;
      tmo_p_q <= tmo_hit;
    end
  end

  assign TX       = tx_sh_q[0];
  assign resp     = resp_q;
  assign resp_rdy = rdy_q;
  assign cmd_done = done_q;
  assign timeout  = tmo_p_q;

endmodule
